// File: rtl/hybrid_adder_pipe_if.sv
// Operand/result stream bundle for the two-stage hybrid adder.
// master = producer of operands and consumer of results, slave = the adder.
interface hybrid_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Xi;
    logic [WIDTH-1:0] Yi;
    logic             C0;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Si;
    logic             Cout;
    logic             V;
    logic             Z;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output Xi, Yi, C0, sub, in_valid, out_ready,
        input  in_ready, Si, Cout, V, Z, out_valid
    );

    modport slave (
        input  Xi, Yi, C0, sub, in_valid, out_ready,
        output in_ready, Si, Cout, V, Z, out_valid
    );
endinterface

// File: rtl/hybrid_adder_pipe.sv
// Two-stage pipelined add/subtract unit. Stage 1 adds the lower half with
// grouped carry-lookahead, stage 2 finishes the upper half from the
// registered lower carry and produces the flags. Valid/ready handshake on
// both sides, two operations in flight.
module hybrid_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    hybrid_adder_pipe_if.slave bus
);
    localparam int HALF = WIDTH / 2;
    localparam int NGRP = HALF / GRP;

    // Half-width adder: GRP-bit lookahead groups, carry ripples group to group.
    // Returns {carry_out, sum}.
    function automatic logic [HALF:0] cla_add(
        input logic [HALF-1:0] x,
        input logic [HALF-1:0] y,
        input logic            cin
    );
        logic [HALF-1:0] p;
        logic [HALF-1:0] g;
        logic [HALF-1:0] s;
        logic            c_grp;
        logic            gg;
        logic            pp;
        p     = x ^ y;
        g     = x & y;
        s     = '0;
        c_grp = cin;
        for (int k = 0; k < NGRP; k++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = 0; j < GRP; j++) begin
                // carry into bit j expressed from the group's prefix G/P and group carry-in
                s[k*GRP+j] = p[k*GRP+j] ^ (gg | (pp & c_grp));
                gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
                pp = pp & p[k*GRP+j];
            end
            c_grp = gg | (pp & c_grp);
        end
        return {c_grp, s};
    endfunction

    logic             v1;
    logic             v2;
    logic [HALF-1:0]  s1_lo;
    logic             c1_lo;
    logic [HALF-1:0]  x1_hi;
    logic [HALF-1:0]  y1_hi;
    logic             x1_msb;
    logic             y1_msb;

    logic [WIDTH-1:0] si_q;
    logic             cout_q;
    logic             v_q;
    logic             z_q;

    logic [WIDTH-1:0] y_eff;
    logic             c_in;
    logic [HALF:0]    lo_sum;
    logic [HALF:0]    hi_sum;
    logic [WIDTH-1:0] si_next;
    logic             v_next;
    logic             accept;
    logic             load2;

    // Handshake: stage 2 frees whenever it is empty or being drained;
    // in_ready depends only on state and out_ready, never on in_valid.
    assign bus.in_ready  = ~v1 | ~v2 | bus.out_ready;
    assign accept        = bus.in_valid & bus.in_ready;
    assign load2         = v1 & (~v2 | bus.out_ready);
    assign bus.out_valid = v2;
    assign bus.Si        = si_q;
    assign bus.Cout      = cout_q;
    assign bus.V         = v_q;
    assign bus.Z         = z_q;

    // Datapath for both halves; subtract is X + ~Y + 1.
    always_comb begin
        y_eff   = bus.Yi ^ {WIDTH{bus.sub}};
        c_in    = bus.sub | bus.C0;
        lo_sum  = cla_add(bus.Xi[HALF-1:0], y_eff[HALF-1:0], c_in);
        hi_sum  = cla_add(x1_hi, y1_hi, c1_lo);
        si_next = {hi_sum[HALF-1:0], s1_lo};
        v_next  = (x1_msb == y1_msb) & (si_next[WIDTH-1] != x1_msb);
    end

    // Stage 1: lower sum and carry, upper operand halves and signs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_lo  <= '0;
            c1_lo  <= 1'b0;
            x1_hi  <= '0;
            y1_hi  <= '0;
            x1_msb <= 1'b0;
            y1_msb <= 1'b0;
        end else begin
            v1 <= accept | (v1 & ~load2);
            if (accept) begin
                s1_lo  <= lo_sum[HALF-1:0];
                c1_lo  <= lo_sum[HALF];
                x1_hi  <= bus.Xi[WIDTH-1:HALF];
                y1_hi  <= y_eff[WIDTH-1:HALF];
                x1_msb <= bus.Xi[WIDTH-1];
                y1_msb <= y_eff[WIDTH-1];
            end
        end
    end

    // Stage 2: full result and flags, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            si_q   <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            v2 <= load2 | (v2 & ~bus.out_ready);
            if (load2) begin
                si_q   <= si_next;
                cout_q <= hi_sum[HALF];
                v_q    <= v_next;
                z_q    <= (si_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_hybrid_adder_pipe.sv
// Self-checking bench for hybrid_adder_pipe (WIDTH=16, GRP=4).
module tb_hybrid_adder_pipe;
    logic clk = 1'b0;
    logic rst_n;

    hybrid_adder_pipe_if #(.WIDTH(16)) bus ();

    hybrid_adder_pipe #(.WIDTH(16), .GRP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        logic        z;
        int          cyc;
    } res_t;

    res_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    bit   lat_mode = 1'b0;

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic res_t model(logic [15:0] x, logic [15:0] y, logic c0, logic sb);
        res_t r;
        int   sx;
        int   sy;
        int   t;
        int   ux;
        int   uy;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sb) begin
            r.s = 16'(ux - uy);
            r.c = (ux >= uy);
            t   = sx - sy;
        end else begin
            r.s = 16'(ux + uy + int'(c0));
            r.c = (ux + uy + int'(c0)) > 65535;
            t   = sx + sy + int'(c0);
        end
        r.v   = (t > 32767) || (t < -32768);
        r.z   = (r.s == 16'h0000);
        r.cyc = 0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c0,
                         input logic sb, input logic iv, input logic ordy);
        bus.Xi        = x;
        bus.Yi        = y;
        bus.C0        = c0;
        bus.sub       = sb;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
    endtask

    task automatic drive_idle(input logic ordy);
        drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, ordy);
    endtask

    // One clock: sample both handshakes at the falling edge, score, then advance.
    task automatic tick(output bit acc);
        res_t r;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else begin
                r = exp_q.pop_front();
                check("out.si",   64'(bus.Si),   64'(r.s));
                check("out.cout", 64'(bus.Cout), 64'(r.c));
                check("out.v",    64'(bus.V),    64'(r.v));
                check("out.z",    64'(bus.Z),    64'(r.z));
                if (lat_mode) check("out.latency", 64'(cyc - r.cyc), 64'd2);
            end
        end
        if (acc) begin
            r     = model(bus.Xi, bus.Yi, bus.C0, bus.sub);
            r.cyc = cyc;
            exp_q.push_back(r);
            n_acc++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 12 && exp_q.size() != 0; k++) begin
            drive_idle(1'b1);
            tick(acc);
        end
        check("drain.empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic dir_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic c0, input logic sb, input logic [15:0] es,
                          input logic ec, input logic ev, input logic ez);
        bit acc;
        lat_mode = 1'b1;
        drive(x, y, c0, sb, 1'b1, 1'b1);
        tick(acc);
        check({tag, ".acc"}, 64'(acc), 64'd1);
        drive_idle(1'b1);
        check({tag, ".ov_c1"}, 64'(bus.out_valid), 64'd0);
        tick(acc);
        check({tag, ".ov_c2"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".si"},    64'(bus.Si),   64'(es));
        check({tag, ".cout"},  64'(bus.Cout), 64'(ec));
        check({tag, ".v"},     64'(bus.V),    64'(ev));
        check({tag, ".z"},     64'(bus.Z),    64'(ez));
        tick(acc);
    endtask

    initial begin : main
        bit          acc;
        int          acc0;
        int          budget;
        res_t        ra;
        logic [15:0] ox;
        logic [15:0] oy;
        logic        oc;
        logic        os;
        int          done;

        rst_n = 1'b1;
        drive_idle(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.si",        64'(bus.Si),        64'd0);
        check("rst.flags",     64'({bus.Cout, bus.V, bus.Z}), 64'd0);
        check("rst.in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First acceptance right after reset release, then the corner values.
        dir_op("add_carry8", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        dir_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        dir_op("add_ovf",    16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        dir_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        dir_op("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Back-pressure: three ops offered while the consumer stalls for four cycles.
        lat_mode = 1'b0;
        acc0 = n_acc;
        ra   = model(16'h1234, 16'h1111, 1'b0, 1'b0);
        drive(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0);
        check("stall.rdy1", 64'(bus.in_ready), 64'd1);
        tick(acc);
        drive(16'h4000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stall.rdy2", 64'(bus.in_ready), 64'd1);
        tick(acc);
        drive(16'hABCD, 16'h5432, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stall.rdy3", 64'(bus.in_ready), 64'd0);
        check("stall.ov3",  64'(bus.out_valid), 64'd1);
        check("stall.si3",  64'(bus.Si), 64'(ra.s));
        tick(acc);
        check("stall.rdy4", 64'(bus.in_ready), 64'd0);
        check("stall.si4",  64'(bus.Si), 64'(ra.s));
        check("stall.flags4", 64'({bus.Cout, bus.V, bus.Z}), 64'({ra.c, ra.v, ra.z}));
        tick(acc);
        check("stall.accepted", 64'(n_acc - acc0), 64'd2);
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) tick(acc);
        check("stall.third_acc", 64'(acc), 64'd1);
        drain();
        check("stall.total", 64'(n_acc - acc0), 64'd3);

        // Back-to-back random stream, one result per cycle after two cycles.
        lat_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            tick(acc);
            if (!acc) check("stream.acc", 64'(acc), 64'd1);
        end
        drain();

        // Random traffic with random consumer stalls; order is checked by the queue.
        lat_mode = 1'b0;
        done   = 0;
        budget = 0;
        ox = 16'($urandom); oy = 16'($urandom); oc = 1'($urandom); os = 1'($urandom);
        while (done < 30 && budget < 400) begin
            drive(ox, oy, oc, os, 1'($urandom), 1'($urandom));
            tick(acc);
            if (acc) begin
                done++;
                ox = 16'($urandom); oy = 16'($urandom); oc = 1'($urandom); os = 1'($urandom);
            end
            budget++;
        end
        check("rand.done", 64'(done), 64'd30);
        drain();

        // Asynchronous reset with both stages full.
        drive(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(acc);
        drive(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(acc);
        drive_idle(1'b0);
        check("arst.full", 64'(bus.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 64'(bus.out_valid), 64'd0);
        check("arst.si",        64'(bus.Si), 64'd0);
        check("arst.flags",     64'({bus.Cout, bus.V, bus.Z}), 64'd0);
        check("arst.in_ready",  64'(bus.in_ready), 64'd1);
        exp_q.delete();
        drive_idle(1'b1);
        tick(acc);
        rst_n = 1'b1;
        dir_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        drive_idle(1'b1);
        tick(acc);
        check("post_rst.no_stale", 64'(bus.out_valid), 64'd0);
        check("post_rst.q_empty",  64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
